// File: rtl/mux4_rr_sequencer_pkg.sv
// Shared types and constants for the round-robin select sequencer that drives
// the 4-to-1 mux selects.
package mux4_rr_sequencer_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/mux4_rr_sequencer_if.sv
// Request/select bundle between the request sources, the sequencer and the
// downstream consumer of the mux output.
interface mux4_rr_sequencer_if;

  logic [mux4_rr_sequencer_pkg::NCH-1:0] req;
  logic                                  out_ready;
  logic                                  s1;
  logic                                  s0;
  logic                                  sel_valid;
  logic [mux4_rr_sequencer_pkg::NCH-1:0] gnt;
  logic                                  last;

  modport master (
    input  req, out_ready,
    output s1, s0, sel_valid, gnt, last
  );

  modport slave (
    output req, out_ready,
    input  s1, s0, sel_valid, gnt, last
  );

endinterface

// File: rtl/mux4_rr_sequencer_rr_pick4.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux4_rr_sequencer_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pick = ptr;
    any  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      logic [SEL_W-1:0] idx;
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sequencer.sv
// Round-robin grant sequencer: holds a registered mux select for a burst of
// up to BURST handshaken beats, with an idle cycle between grants.
module mux4_rr_sequencer
  import mux4_rr_sequencer_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_sequencer_if.master bus
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic             sel_valid_q;
  logic [NCH-1:0]   gnt_q;

  logic [SEL_W-1:0] pick;
  logic             any;
  logic             req_sel;
  logic             beat;
  logic             at_end;

  rr_pick4 u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign req_sel = bus.req[sel];
  assign beat    = sel_valid_q & bus.out_ready;
  assign at_end  = (cnt == CNT_W'(BURST - 1));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every branch reads
    // the pre-edge values of sel/cnt/ptr regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      sel         <= '0;
      cnt         <= '0;
      sel_valid_q <= 1'b0;
      gnt_q       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            sel         <= pick;
            cnt         <= '0;
            sel_valid_q <= 1'b1;
            gnt_q       <= sel_onehot(pick);
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A withdrawn request ends the grant whether or not this cycle is a beat.
          if ((beat && at_end) || !req_sel) begin
            ptr         <= sel + SEL_W'(1);
            cnt         <= '0;
            sel_valid_q <= 1'b0;
            gnt_q       <= '0;
            state       <= ST_IDLE;
          end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Selects hold their last value through IDLE; only a new pick changes them.
  assign bus.s1        = sel[1];
  assign bus.s0        = sel[0];
  assign bus.sel_valid = sel_valid_q;
  assign bus.gnt       = gnt_q;
  assign bus.last      = sel_valid_q & (at_end | !req_sel);

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Directed self-checking bench for the round-robin select sequencer.
module tb_mux4_rr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux4_rr_sequencer_if bus ();

  mux4_rr_sequencer #(.BURST(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid cyc%0d: got %b want 0", c, bus.sel_valid); end
      checks++;
      if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt cyc%0d: got %b want 0000", c, bus.gnt); end
      checks++;
      if ({bus.s1, bus.s0} !== 2'b00) begin errors++; $display("FAIL reset_sel cyc%0d: got %b want 00", c, {bus.s1, bus.s0}); end
      checks++;
      if (bus.last !== 1'b0) begin errors++; $display("FAIL reset_last cyc%0d: got %b want 0", c, bus.last); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (bus.sel_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat%0d: got %b want 1", b, bus.sel_valid); end
      checks++;
      if ({bus.s1, bus.s0} !== 2'b10) begin errors++; $display("FAIL single_sel beat%0d: got %b want 10", b, {bus.s1, bus.s0}); end
      checks++;
      if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt beat%0d: got %b want 0100", b, bus.gnt); end
      checks++;
      if (bus.last !== (b == 3)) begin errors++; $display("FAIL single_last beat%0d: got %b want %b", b, bus.last, (b == 3)); end
      step();
    end
    checks++;
    if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL single_gap_valid: got %b want 0", bus.sel_valid); end
    checks++;
    if ({bus.s1, bus.s0} !== 2'b10) begin errors++; $display("FAIL single_gap_hold: got %b want 10", {bus.s1, bus.s0}); end
    step();
    checks++;
    if (bus.sel_valid !== 1'b1 || {bus.s1, bus.s0} !== 2'b10) begin
      errors++; $display("FAIL single_regrant: got valid=%b sel=%b want valid=1 sel=10", bus.sel_valid, {bus.s1, bus.s0});
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_sel;
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    for (int g = 0; g < 5; g++) begin
      exp_sel = 2'(g % 4);
      exp_gnt = 4'b0001 << exp_sel;
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (bus.sel_valid !== 1'b1 || {bus.s1, bus.s0} !== exp_sel || bus.gnt !== exp_gnt) begin
          errors++; $display("FAIL fair_grant g%0d b%0d: got valid=%b sel=%b gnt=%b want valid=1 sel=%b gnt=%b",
                             g, b, bus.sel_valid, {bus.s1, bus.s0}, bus.gnt, exp_sel, exp_gnt);
        end
        checks++;
        if (bus.last !== (b == 3)) begin errors++; $display("FAIL fair_last g%0d b%0d: got %b want %b", g, b, bus.last, (b == 3)); end
        step();
      end
      checks++;
      if (bus.sel_valid !== 1'b0 || bus.gnt !== 4'b0000) begin
        errors++; $display("FAIL fair_gap g%0d: got valid=%b gnt=%b want valid=0 gnt=0000", g, bus.sel_valid, bus.gnt);
      end
      step();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req = 4'b0010;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if ({bus.s1, bus.s0} !== 2'b01 || bus.last !== 1'b0) begin
      errors++; $display("FAIL early_beat1: got sel=%b last=%b want sel=01 last=0", {bus.s1, bus.s0}, bus.last);
    end
    step();
    bus.req = 4'b1101;
    #1;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.last !== 1'b1) begin
      errors++; $display("FAIL early_last: got valid=%b last=%b want valid=1 last=1", bus.sel_valid, bus.last);
    end
    step();
    checks++;
    if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL early_drop: got %b want 0", bus.sel_valid); end
    step();
    checks++;
    if (bus.sel_valid !== 1'b1 || {bus.s1, bus.s0} !== 2'b10) begin
      errors++; $display("FAIL early_next: got valid=%b sel=%b want valid=1 sel=10", bus.sel_valid, {bus.s1, bus.s0});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req = 4'b1000;
    bus.out_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.sel_valid !== 1'b1 || {bus.s1, bus.s0} !== 2'b11 || bus.last !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d: got valid=%b sel=%b last=%b want valid=1 sel=11 last=0",
                           c, bus.sel_valid, {bus.s1, bus.s0}, bus.last);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (bus.sel_valid !== 1'b1 || bus.last !== (b == 3)) begin
        errors++; $display("FAIL bp_beat b%0d: got valid=%b last=%b want valid=1 last=%b", b, bus.sel_valid, bus.last, (b == 3));
      end
      step();
    end
    checks++;
    if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got %b want 0", bus.sel_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.sel_valid !== 1'b0 || bus.gnt !== 4'b0000 || {bus.s1, bus.s0} !== 2'b00 || bus.last !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got valid=%b gnt=%b sel=%b last=%b want 0/0000/00/0",
                         bus.sel_valid, bus.gnt, {bus.s1, bus.s0}, bus.last);
    end
    bus.req = 4'b1111;
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.sel_valid !== 1'b1 || {bus.s1, bus.s0} !== 2'b00 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_regrant: got valid=%b sel=%b gnt=%b want 1/00/0001",
                         bus.sel_valid, {bus.s1, bus.s0}, bus.gnt);
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
